// File: rtl/cpu_pkg.sv
// Shared constants for the 3-bit-opcode accumulator CPU controller:
// state encodings, opcodes and the opcode-field helper.
package cpu_pkg;

    localparam logic [2:0] S_FETCH   = 3'b000;
    localparam logic [2:0] S_DECODE  = 3'b001;
    localparam logic [2:0] S_ILLEGAL = 3'b010;
    localparam logic [2:0] S_EX_IN   = 3'b011;
    localparam logic [2:0] S_EX_OUT  = 3'b100;
    localparam logic [2:0] S_EX_DEC  = 3'b101;
    localparam logic [2:0] S_EX_JNZ  = 3'b110;
    localparam logic [2:0] S_HALT    = 3'b111;

    localparam logic [2:0] OP_IN   = 3'b011;
    localparam logic [2:0] OP_OUT  = 3'b100;
    localparam logic [2:0] OP_DEC  = 3'b101;
    localparam logic [2:0] OP_JNZ  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam int INSTR_MAX_W = 32;

    // Opcode is the top three bits of an instruction of the given width.
    function automatic logic [2:0] opcode_of(
        input logic [INSTR_MAX_W-1:0] instr,
        input int unsigned            width
    );
        logic [INSTR_MAX_W-1:0] sh;
        sh = instr >> (width - 3);
        return sh[2:0];
    endfunction

endpackage

// File: rtl/ctrl_next_state.sv
// Combinational next-state and retire decode for the CPU sequencer.
// Opcodes above 010 map one-to-one onto their execute state.
module ctrl_next_state
    import cpu_pkg::*;
(
    input  logic [2:0] i_state,
    input  logic [2:0] i_opcode,
    input  logic       i_in_valid,
    input  logic       i_out_ready,
    output logic [2:0] o_next,
    output logic       o_retire
);

    always_comb begin
        o_next   = S_FETCH;
        o_retire = 1'b0;
        unique case (i_state)
            S_FETCH: o_next = S_DECODE;
            S_DECODE: begin
                if (i_opcode > 3'b010)
                    o_next = i_opcode;
                // NOPs and HALT retire on leaving DECODE
                o_retire = (i_opcode <= 3'b010) || (i_opcode == OP_HALT);
            end
            S_EX_IN: begin
                if (i_in_valid)
                    o_retire = 1'b1;
                else
                    o_next = S_EX_IN;
            end
            S_EX_OUT: begin
                if (i_out_ready)
                    o_retire = 1'b1;
                else
                    o_next = S_EX_OUT;
            end
            S_EX_DEC: o_retire = 1'b1;
            S_EX_JNZ: o_retire = 1'b1;
            S_HALT:   o_next = S_HALT;
            default:  o_next = S_FETCH;
        endcase
    end

endmodule

// File: rtl/cpu_control_unit.sv
// Sequencing controller: state, pc, ir and retire counter, with
// Moore strobes and IN/OUT valid/ready handshakes.
module cpu_control_unit
    import cpu_pkg::*;
#(
    parameter int PC_W    = 5,
    parameter int INSTR_W = 8,
    parameter int RET_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_rd,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               a_not_zero,
    output logic               a_load,
    output logic               a_dec,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               halted,
    output logic [2:0]         state,
    output logic [INSTR_W-1:0] ir,
    output logic [RET_W-1:0]   retired
);

    logic [2:0]         r_state;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_ir;
    logic [RET_W-1:0]   r_retired;
    logic [2:0]         w_opcode;
    logic [2:0]         w_next;
    logic               w_retire;

    // Decode sees the fresh memory word, not the stale ir
    assign w_opcode = opcode_of(INSTR_MAX_W'(imem_rdata), INSTR_W);

    ctrl_next_state u_next (
        .i_state     (r_state),
        .i_opcode    (w_opcode),
        .i_in_valid  (in_valid),
        .i_out_ready (out_ready),
        .o_next      (w_next),
        .o_retire    (w_retire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_pc      <= '0;
            r_ir      <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire)
                r_retired <= r_retired + RET_W'(1);
            if (r_state == S_DECODE) begin
                r_ir <= imem_rdata;
                r_pc <= r_pc + PC_W'(1);
            end else if (r_state == S_EX_JNZ && a_not_zero) begin
                r_pc <= r_ir[PC_W-1:0];
            end
        end
    end

    // Strobes are forced low while reset is held
    assign imem_rd   = rst_n & (r_state == S_FETCH);
    assign imem_addr = r_pc;
    assign a_load    = rst_n & (r_state == S_EX_IN) & in_valid;
    assign a_dec     = rst_n & (r_state == S_EX_DEC);
    assign in_ready  = rst_n & (r_state == S_EX_IN);
    assign out_valid = rst_n & (r_state == S_EX_OUT);
    assign halted    = rst_n & (r_state == S_HALT);
    assign state     = r_state;
    assign ir        = r_ir;
    assign retired   = r_retired;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: per-cycle expected vectors go
// through a scoreboard queue and are checked with immediate assertions.
module tb_cpu_control_unit;
    import cpu_pkg::*;

    localparam int PW = 5;
    localparam int IW = 8;
    localparam int RW = 8;

    typedef struct packed {
        logic [2:0]    st;
        logic          rd;
        logic [PW-1:0] ad;
        logic          ld;
        logic          dc;
        logic          ir;
        logic          ov;
        logic          hl;
        logic [RW-1:0] rt;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          imem_rd;
    logic [PW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata = '0;
    logic          a_not_zero = 1'b0;
    logic          a_load;
    logic          a_dec;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          halted;
    logic [2:0]    state;
    logic [IW-1:0] ir;
    logic [RW-1:0] retired;

    logic [IW-1:0] mem [0:(1<<PW)-1];
    vec_t          sb [$];
    int            n_vec = 0;
    int            n_err = 0;

    cpu_control_unit #(.PC_W(PW), .INSTR_W(IW), .RET_W(RW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_rd    (imem_rd),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .a_not_zero (a_not_zero),
        .a_load     (a_load),
        .a_dec      (a_dec),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .halted     (halted),
        .state      (state),
        .ir         (ir),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data valid the cycle after imem_rd
    always @(posedge clk)
        if (imem_rd) imem_rdata <= mem[imem_addr];

    task automatic step(input string tag, input logic [2:0] st,
                        input int ad, input int rt,
                        input logic ld = 1'b0, input logic rs = 1'b0);
        vec_t e;
        vec_t o;
        vec_t x;
        e.st = st;
        e.rd = ~rs & (st == S_FETCH);
        e.ad = PW'(ad);
        e.ld = ld;
        e.dc = ~rs & (st == S_EX_DEC);
        e.ir = ~rs & (st == S_EX_IN);
        e.ov = ~rs & (st == S_EX_OUT);
        e.hl = ~rs & (st == S_HALT);
        e.rt = RW'(rt);
        sb.push_back(e);
        #1;
        o = {state, imem_rd, imem_addr, a_load, a_dec,
             in_ready, out_valid, halted, retired};
        x = sb.pop_front();
        n_vec++;
        assert (o === x) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, o, x);
        end
        @(negedge clk);
    endtask

    task automatic chk_ir(input string tag, input logic [IW-1:0] v);
        n_vec++;
        assert (ir === v) else begin
            n_err++;
            $error("FAIL %s: observed ir %h expected %h", tag, ir, v);
        end
    endtask

    task automatic clear_mem;
        for (int i = 0; i < (1 << PW); i++) mem[i] = '0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        step("reset", S_FETCH, 0, 0, 1'b0, 1'b1);
        rst_n = 1'b1;
    endtask

    initial begin
        clear_mem();
        @(negedge clk);

        // NOP, DEC, HALT
        mem[0] = 8'h00; mem[1] = 8'hA0; mem[2] = 8'hE0;
        do_reset();
        step("p1_f0", S_FETCH, 0, 0);
        step("p1_d0", S_DECODE, 0, 0);
        step("p1_f1", S_FETCH, 1, 1);
        step("p1_d1", S_DECODE, 1, 1);
        step("p1_dec", S_EX_DEC, 2, 1);
        step("p1_f2", S_FETCH, 2, 2);
        step("p1_d2", S_DECODE, 2, 2);
        step("p1_h0", S_HALT, 3, 3);
        step("p1_h1", S_HALT, 3, 3);
        step("p1_h2", S_HALT, 3, 3);
        chk_ir("p1_ir", 8'hE0);

        // IN, OUT, JNZ taken twice / not taken, HALT
        rst_n = 1'b0;
        clear_mem();
        mem[0] = 8'h60; mem[1] = 8'h80; mem[2] = 8'hC5;
        mem[3] = 8'hE0; mem[5] = 8'hC2;
        do_reset();
        step("p2_f0", S_FETCH, 0, 0);
        step("p2_d0", S_DECODE, 0, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step("p2_in_stall", S_EX_IN, 1, 0);
        in_valid = 1'b1;
        step("p2_in_acc", S_EX_IN, 1, 0, 1'b1);
        in_valid = 1'b0;
        out_ready = 1'b0;
        step("p2_f1", S_FETCH, 1, 1);
        step("p2_d1", S_DECODE, 1, 1);
        for (int i = 0; i < 3; i++) step("p2_out_stall", S_EX_OUT, 2, 1);
        out_ready = 1'b1;
        step("p2_out_acc", S_EX_OUT, 2, 1);
        out_ready = 1'b0;
        step("p2_f2", S_FETCH, 2, 2);
        step("p2_d2", S_DECODE, 2, 2);
        a_not_zero = 1'b1;
        step("p2_jnz_t", S_EX_JNZ, 3, 2);
        chk_ir("p2_ir", 8'hC5);
        step("p2_f5", S_FETCH, 5, 3);
        step("p2_d5", S_DECODE, 5, 3);
        step("p2_jnz_back", S_EX_JNZ, 6, 3);
        step("p2_f2b", S_FETCH, 2, 4);
        step("p2_d2b", S_DECODE, 2, 4);
        a_not_zero = 1'b0;
        step("p2_jnz_nt", S_EX_JNZ, 3, 4);
        step("p2_f3", S_FETCH, 3, 5);
        step("p2_d3", S_DECODE, 3, 5);
        step("p2_h0", S_HALT, 4, 6);
        in_valid = 1'b1;
        step("p2_h_in", S_HALT, 4, 6);
        in_valid = 1'b0;

        // PC wrap at 32 and retire counter wrap at 2^RW
        rst_n = 1'b0;
        clear_mem();
        do_reset();
        for (int k = 0; k < 260; k++) begin
            step("p3_f", S_FETCH, k % 32, k);
            step("p3_d", S_DECODE, k % 32, k);
        end

        // Asynchronous reset in the middle of an IN stall
        rst_n = 1'b0;
        clear_mem();
        mem[1] = 8'h60;
        do_reset();
        step("p4_f0", S_FETCH, 0, 0);
        step("p4_d0", S_DECODE, 0, 0);
        step("p4_f1", S_FETCH, 1, 1);
        step("p4_d1", S_DECODE, 1, 1);
        step("p4_in0", S_EX_IN, 2, 1);
        step("p4_in1", S_EX_IN, 2, 1);
        #3;
        rst_n = 1'b0;
        step("p4_rst", S_FETCH, 0, 0, 1'b0, 1'b1);
        rst_n = 1'b1;
        step("p4_f0b", S_FETCH, 0, 0);
        step("p4_d0b", S_DECODE, 0, 0);
        step("p4_f1b", S_FETCH, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
